// File: rtl/vc_net_mem_adapter_mo.sv
`default_nettype none
// ============================================================================
// Module   : vc_net_mem_adapter_mo
// Purpose  : Network-to-memory adapter with up to p_max_outstanding in-flight
//            memory requests. Strips the {dest,src} header from each incoming
//            network request and forwards the payload to an in-order memory
//            port. It keeps the swapped routing info ({req_src,req_dest}) in a
//            circular tag queue, and re-wraps each memory response with the
//            oldest tag before it enters the response network.
// Ports    : clk, reset_n (async, active-low)
//            netout_msg/val/rdy  : request network egress  {dest,src,payload}
//            memreq_msg/val/rdy  : memory request port (payload pass-through)
//            memresp_msg/val/rdy : memory response port
//            netin_msg/val/rdy   : response network ingress {dest,src,resp}
//            outstanding         : current tag queue occupancy
// Revision : 1.0 - initial release
// ============================================================================

`ifndef VC_MEM_REQ_MSG_SZ
`define VC_MEM_REQ_MSG_SZ(a_, d_) (1 + (a_) + $clog2((d_) / 8) + (d_))
`endif
`ifndef VC_MEM_RESP_MSG_SZ
`define VC_MEM_RESP_MSG_SZ(d_) (1 + $clog2((d_) / 8) + (d_))
`endif
`ifndef VC_NET_MSG_SZ
`define VC_NET_MSG_SZ(p_, s_) ((p_) + 2 * (s_))
`endif

module vc_net_mem_adapter_mo #(
    parameter int p_num_nodes       = 4,
    parameter int p_addr_sz         = 8,
    parameter int p_data_sz         = 32,
    parameter int p_max_outstanding = 4,
    localparam int c_srcdest_sz     = $clog2(p_num_nodes),
    localparam int c_cnt_sz         = $clog2(p_max_outstanding + 1),
    localparam int c_memreq_msg_sz  = `VC_MEM_REQ_MSG_SZ(p_addr_sz, p_data_sz),
    localparam int c_memresp_msg_sz = `VC_MEM_RESP_MSG_SZ(p_data_sz),
    localparam int c_reqnet_msg_sz  = `VC_NET_MSG_SZ(c_memreq_msg_sz, c_srcdest_sz),
    localparam int c_respnet_msg_sz = `VC_NET_MSG_SZ(c_memresp_msg_sz, c_srcdest_sz)
) (
    input  logic                        clk,
    input  logic                        reset_n,

    input  logic [c_reqnet_msg_sz-1:0]  netout_msg,
    input  logic                        netout_val,
    output logic                        netout_rdy,

    output logic [c_memreq_msg_sz-1:0]  memreq_msg,
    output logic                        memreq_val,
    input  logic                        memreq_rdy,

    input  logic [c_memresp_msg_sz-1:0] memresp_msg,
    input  logic                        memresp_val,
    output logic                        memresp_rdy,

    output logic [c_respnet_msg_sz-1:0] netin_msg,
    output logic                        netin_val,
    input  logic                        netin_rdy,

    output logic [c_cnt_sz-1:0]         outstanding
);

    localparam int c_ptr_sz = (p_max_outstanding > 1) ? $clog2(p_max_outstanding) : 1;
    localparam int c_tag_sz = 2 * c_srcdest_sz;
    localparam logic [c_cnt_sz-1:0] c_max_cnt  = c_cnt_sz'(p_max_outstanding);
    localparam logic [c_ptr_sz-1:0] c_last_ptr = c_ptr_sz'(p_max_outstanding - 1);

    // Tag entries hold {resp_dest, resp_src} = {req_src, req_dest}.
    logic [c_tag_sz-1:0]     r_tags [p_max_outstanding];
    logic [c_ptr_sz-1:0]     r_enq_ptr;
    logic [c_ptr_sz-1:0]     r_deq_ptr;
    logic [c_cnt_sz-1:0]     r_count;

    logic                    w_nonempty;
    logic                    w_deq;
    logic                    w_enq;
    logic                    w_can_enq;
    logic [c_srcdest_sz-1:0] w_req_dest;
    logic [c_srcdest_sz-1:0] w_req_src;
    logic [c_tag_sz-1:0]     w_head;

    // Modulo increment so non-power-of-two depths wrap correctly.
    function automatic logic [c_ptr_sz-1:0] f_wrap_inc(input logic [c_ptr_sz-1:0] p);
        return (p == c_last_ptr) ? '0 : p + 1'b1;
    endfunction

    assign w_req_dest = netout_msg[c_reqnet_msg_sz-1 -: c_srcdest_sz];
    assign w_req_src  = netout_msg[c_reqnet_msg_sz-c_srcdest_sz-1 -: c_srcdest_sz];
    assign w_head     = r_tags[r_deq_ptr];

    // No empty bypass: a response only pairs with a tag written in an
    // earlier cycle, so everything on the response side keys off count.
    assign w_nonempty = (r_count != '0);
    assign w_deq      = memresp_val && netin_rdy && w_nonempty;

    // A dequeue in the same cycle frees a slot even when the queue is full.
    assign w_can_enq  = (r_count < c_max_cnt) || w_deq;

    // Handshake outputs are gated by reset_n so they drop the moment reset
    // asserts, independent of the clock.
    assign netout_rdy  = reset_n && memreq_rdy && w_can_enq;
    assign memreq_val  = reset_n && netout_val && w_can_enq;
    assign memresp_rdy = reset_n && netin_rdy && w_nonempty;
    assign netin_val   = reset_n && memresp_val && w_nonempty;

    assign w_enq       = netout_val && netout_rdy;

    assign memreq_msg  = netout_msg[c_memreq_msg_sz-1:0];
    assign netin_msg   = {w_head, memresp_msg};
    assign outstanding = r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_enq_ptr <= '0;
            r_deq_ptr <= '0;
            r_count   <= '0;
        end else begin
            if (w_enq) begin
                r_enq_ptr <= f_wrap_inc(r_enq_ptr);
            end
            if (w_deq) begin
                r_deq_ptr <= f_wrap_inc(r_deq_ptr);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Tag storage carries no reset; stale entries are never read because
    // count gates every use of the head.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_tags[r_enq_ptr] <= {w_req_src, w_req_dest};
        end
    end

    // A response with nothing outstanding simply stalls; flag it as a warning.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(memresp_val && !w_nonempty))
            else $warning("memresp_val seen with no outstanding request; response stalled");
        end
    end

endmodule

`default_nettype wire

// File: doc/vc_net_mem_adapter_mo.md
Name: vc_net_mem_adapter_mo

Overview:
Network-to-memory adapter that supports up to p_max_outstanding in-flight memory requests. It strips the network header from each incoming request and forwards the payload to a memory port. It keeps the swapped {src,dest} routing info in an internal in-order tag queue. Each memory response is re-wrapped with the oldest tag and injected into the response network. It sits between a node's request-network egress, a single in-order memory port, and the response-network ingress.

Parameters:
p_num_nodes, 4, number of network nodes
p_addr_sz, 8, memory request address width
p_data_sz, 32, memory data width
p_max_outstanding, 4, tag queue depth (>=1); maximum accepted-but-unanswered requests
c_srcdest_sz, $clog2(p_num_nodes), src/dest field width (local)
c_cnt_sz, $clog2(p_max_outstanding+1), occupancy counter width (local)
c_memreq_msg_sz / c_memresp_msg_sz, `VC_MEM_REQ_MSG_SZ(p_addr_sz,p_data_sz) / `VC_MEM_RESP_MSG_SZ(p_data_sz) (local)
c_reqnet_msg_sz / c_respnet_msg_sz, `VC_NET_MSG_SZ(payload,c_srcdest_sz) (local)

Ports:
clk  in  1  clock; all state on posedge
reset_n  in  1  asynchronous, active-low reset
netout_msg  in  c_reqnet_msg_sz  request from network: {dest,src,payload}, dest in MSBs
netout_val  in  1  request valid
netout_rdy  out  1  request ready
memreq_msg  out  c_memreq_msg_sz  payload field of netout_msg, passed through combinationally
memreq_val  out  1  memory request valid
memreq_rdy  in  1  memory request ready
memresp_msg  in  c_memresp_msg_sz  memory response
memresp_val  in  1  memory response valid
memresp_rdy  out  1  memory response ready
netin_msg  out  c_respnet_msg_sz  {tag.dest,tag.src,memresp_msg}
netin_val  out  1  response valid
netin_rdy  in  1  response network ready
outstanding  out  c_cnt_sz  current tag queue occupancy

Behaviour:
- State: circular tag queue of p_max_outstanding entries, each {resp_dest=req_src, resp_src=req_dest}. Also enq_ptr, deq_ptr and count. Pointers wrap modulo p_max_outstanding, including non-power-of-2 depths.
- Reset (reset_n low, asynchronous): count=0 and pointers=0 immediately. While reset_n is low, netout_rdy, memreq_val, memresp_rdy and netin_val are forced to 0. Tag contents are don't-care. outstanding=0.
- deq = memresp_val && netin_rdy && count!=0.
- can_enq = count<p_max_outstanding || deq. A same-cycle dequeue frees a slot when full (pipe-queue bypass).
- memreq_val = netout_val && can_enq. netout_rdy = memreq_rdy && can_enq.
- enq = netout_val && netout_rdy. On enq, write the tag at enq_ptr.
- netin_val = memresp_val && count!=0. memresp_rdy = netin_rdy && count!=0.
- netin_msg uses the head tag (deq_ptr). The path is purely combinational from memresp_msg; no added latency on either path.
- No empty bypass: a response can only match a request accepted in an earlier cycle. While count==0, memresp_rdy=0 and netin_val=0.
- count update: enq&&!deq gives +1; deq&&!enq gives -1; both or neither leave it unchanged. Simultaneous enq/deq on a full queue keeps count=max, and both pointers advance.
- Ordering: responses must return from memory in request order. Tags are consumed strictly FIFO.
- Overflow and underflow are impossible by construction. Simulation assertions flag memresp_val with count==0 held for >0 cycles only as a warning, not as an error.
- Reset mid-operation: all in-flight tags are discarded. Later memory responses stall (memresp_rdy=0) until a new request is accepted.

Test Plan:
- Single request: 4 nodes, depth 4; netout_msg dest=2, src=1, read addr 0x10. Expected: memreq_val same cycle with payload intact, outstanding=1. Memory responds data 0xCAFEF00D; netin_msg dest=1, src=2, outstanding returns to 0.
- Pipelined: 4 requests from src=0,1,2,3 back-to-back with memreq_rdy=1. Expected: outstanding reaches 4 and a fifth request sees netout_rdy=0. In-order responses emerge with dest 0,1,2,3.
- Full bypass: full queue; in the same cycle, response accepted (netin_rdy=1) and new request presented. Expected: netout_rdy=1, both fire, outstanding stays 4, the new tag appears last.
- Backpressure: netin_rdy=0 with response pending. Expected: memresp_rdy=0, netin_val=1, msg stable. Releasing netin_rdy gives a one-cycle dequeue.
- Spurious response: memresp_val=1 with count=0. Expected: memresp_rdy=0, netin_val=0.
- Async reset: assert reset_n low mid-cycle with 3 outstanding. Expected: outstanding=0 and all val/rdy outputs 0 without waiting for a clock edge. After release, a new request/response pair routes correctly; depth 3 checks pointer wrap.
